// File: rtl/divider_32b_seq.sv
// Sequential signed divider for the DIV instruction: non-restoring division on
// operand magnitudes, one quotient bit per clock, quotient -> LO, remainder -> HI.
module divider_32b_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q, r_m;
  logic             r_sign_q, r_sign_r, r_dbz;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quot, r_rem;
  logic             r_dbz_out;

  logic [WIDTH:0]   w_shift_a, w_m_ext, w_opa, w_opb, w_sum;
  logic             w_sub;
  logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag, w_rem_mag;

  assign w_dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign w_dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;

  // One adder serves both the iteration steps and the final remainder restore;
  // subtraction is A + ~M + 1 with the +1 on the carry-in.
  assign w_shift_a = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_m_ext   = {1'b0, r_m};
  assign w_opa     = (r_state == S_FIX) ? r_a : w_shift_a;
  assign w_sub     = (r_state == S_ITER) && !r_a[WIDTH];
  assign w_opb     = w_sub ? ~w_m_ext : w_m_ext;
  assign w_sum     = w_opa + w_opb + {{WIDTH{1'b0}}, w_sub};
  assign w_rem_mag = r_a[WIDTH] ? w_sum[WIDTH-1:0] : r_a[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
      r_dbz     <= 1'b0;
      r_cnt     <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_dbz_out <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_q      <= w_dvd_mag;
            r_m      <= w_dvs_mag;
            r_a      <= '0;
            r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_sign_r <= dividend[WIDTH-1];
            r_dbz    <= (divisor == '0);
            r_cnt    <= '0;
            r_state  <= S_ITER;
          end
        end
        S_ITER: begin
          r_a   <= w_sum;
          r_q   <= {r_q[WIDTH-2:0], ~w_sum[WIDTH]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH-1)) r_state <= S_FIX;
        end
        S_FIX: begin
          r_a       <= r_a[WIDTH] ? w_sum : r_a;
          // With M=0 the magnitude shifts intact into A, so only Q needs forcing.
          r_quot    <= r_dbz ? '1 : (r_sign_q ? -r_q : r_q);
          r_rem     <= r_sign_r ? -w_rem_mag : w_rem_mag;
          r_dbz_out <= r_dbz;
          r_state   <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state == S_ITER) || (r_state == S_FIX);
  assign done        = (r_state == S_DONE);
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz_out;

endmodule

// File: tb/tb_divider_32b_seq.sv
// Directed and random checks of divider_32b_seq: results, signs, edge values,
// divide-by-zero, ignored start, reset abort and exact 33-cycle latency.
module tb_divider_32b_seq;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int checks = 0;
  int failures = 0;

  divider_32b_seq dut (
    .clk(clk), .reset(reset), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Issues one op and returns at the negedge where done is seen (or budget expiry).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int bcnt, output bit got);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    bcnt = 0; got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (done) begin got = 1'b1; break; end
      if (busy) bcnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 67'd0) begin
      failures++;
      $display("FAIL reset_state got busy=%b done=%b dbz=%b q=%h r=%h want all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int bc; bit got;
    run_op(32'd100, 32'd7, bc, got);
    checks++;
    if (!got || bc != 33) begin
      failures++; $display("FAIL basic_latency got done=%b busy_cycles=%0d want 1/33", got, bc);
    end
    checks++;
    if ({quotient, remainder, div_by_zero} !== {32'h0000000E, 32'h00000002, 1'b0}) begin
      failures++; $display("FAIL basic_100_7 got q=%h r=%h dbz=%b want q=0000000e r=00000002 dbz=0",
                           quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL done_pulse got done=%b busy=%b want 0/0", done, busy);
    end
    checks++;
    if (quotient !== 32'h0000000E || remainder !== 32'h00000002) begin
      failures++; $display("FAIL result_hold got q=%h r=%h want 0000000e/00000002", quotient, remainder);
    end
  endtask

  // Directed table: signs, divide-by-zero and its recovery, edge values.
  task automatic test_vectors;
    logic [31:0] ta[8]  = '{32'hFFFFFF9C, 32'd100, 32'd7, 32'd9, 32'h80000000, 32'h7FFFFFFF, 32'd5, 32'h80000000};
    logic [31:0] tb[8]  = '{32'd7, 32'hFFFFFFF9, 32'd0, 32'd3, 32'hFFFFFFFF, 32'd1, 32'd9, 32'd0};
    logic [31:0] tq[8]  = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'hFFFFFFFF, 32'd3, 32'h80000000, 32'h7FFFFFFF, 32'd0, 32'hFFFFFFFF};
    logic [31:0] tr[8]  = '{32'hFFFFFFFE, 32'd2, 32'd7, 32'd0, 32'd0, 32'd0, 32'd5, 32'h80000000};
    logic        tz[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int bc; bit got;
    for (int i = 0; i < 8; i++) begin
      run_op(ta[i], tb[i], bc, got);
      checks++;
      if (!got || bc != 33) begin
        failures++; $display("FAIL vec%0d_latency got done=%b busy_cycles=%0d want 1/33", i, got, bc);
      end
      checks++;
      if ({quotient, remainder, div_by_zero} !== {tq[i], tr[i], tz[i]}) begin
        failures++; $display("FAIL vec%0d %h/%h got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b", i, ta[i], tb[i],
                             quotient, remainder, div_by_zero, tq[i], tr[i], tz[i]);
      end
    end
  endtask

  task automatic test_start_ignored;
    int ndone = 0;
    @(negedge clk);
    dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    dividend = 32'd1; divisor = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 45; c++) begin
      if (done) begin
        ndone++;
        checks++;
        if (quotient !== 32'd100 || remainder !== 32'd0) begin
          failures++; $display("FAIL start_ignored got q=%h r=%h want 00000064/00000000", quotient, remainder);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (ndone != 1) begin
      failures++; $display("FAIL start_ignored_done_count got %0d want 1", ndone);
    end
  endtask

  task automatic test_reset_abort;
    int ndone = 0;
    @(negedge clk);
    dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL abort_busy_before got %b want 1", busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 67'd0) begin
      failures++; $display("FAIL abort_clear got busy=%b done=%b dbz=%b q=%h r=%h want all 0",
                           busy, done, div_by_zero, quotient, remainder);
    end
    for (int c = 0; c < 40; c++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    checks++;
    if (ndone != 0) begin
      failures++; $display("FAIL abort_no_done got %0d done pulses want 0", ndone);
    end
  endtask

  task automatic test_back_to_back;
    int t0 = -1, t1 = -1;
    @(negedge clk);
    dividend = 32'd21; divisor = 32'd4; start = 1'b1;
    for (int c = 0; c < 100 && t1 < 0; c++) begin
      @(negedge clk);
      if (done) begin
        if (t0 < 0) t0 = c; else t1 = c;
      end
    end
    start = 1'b0;
    checks++;
    if (t0 < 0 || t1 - t0 != 35) begin
      failures++; $display("FAIL back_to_back_period got t0=%0d t1=%0d want period 35", t0, t1);
    end
    checks++;
    if (quotient !== 32'd5 || remainder !== 32'd1) begin
      failures++; $display("FAIL back_to_back_result got q=%h r=%h want 00000005/00000001", quotient, remainder);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    int sd, ss, eq, er, bc; bit got;
    for (int i = 0; i < 1000; i++) begin
      sd = $urandom; ss = $urandom;
      if (i % 3 == 0) ss = ss >>> 20;
      if (ss == 0 || (sd == 32'sh80000000 && ss == -1)) ss = -3;
      eq = sd / ss; er = sd % ss;
      run_op(sd, ss, bc, got);
      checks++;
      if (!got || bc != 33) begin
        failures++; $display("FAIL rand%0d_latency got done=%b busy_cycles=%0d want 1/33", i, got, bc);
      end
      checks++;
      if ({quotient, remainder, div_by_zero} !== {eq, er, 1'b0}) begin
        failures++; $display("FAIL rand%0d %h/%h got q=%h r=%h dbz=%b want q=%h r=%h dbz=0", i, sd, ss,
                             quotient, remainder, div_by_zero, eq, er);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_vectors;
    test_start_ignored;
    test_reset_abort;
    test_back_to_back;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/divider_32b_seq.md
Name: divider_32b_seq

Overview:
- Multi-cycle 32-bit signed integer divider for the Mini SRC datapath's DIV instruction.
- It is the inverse-operation companion to the combinational carry-lookahead adder: it performs repeated add/subtract steps, one bit per clock, using non-restoring division on operand magnitudes.
- Quotient goes to LO and remainder goes to HI through the existing register-load path.
- Control unit drives start/done; the block holds results until the next start.

Parameters:
- WIDTH, 32, operand/result width in bits. The iteration count equals WIDTH.
- CNT_W, 5, iteration counter width. Must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a divide. Sampled only in IDLE.
- dividend  input  WIDTH  signed numerator (two's complement). Sampled with start.
- divisor  input  WIDTH  signed denominator. Sampled with start.
- busy  output  1  high while an operation is in progress (ITER and FIX states).
- done  output  1  one-cycle pulse; results are valid from this cycle onward.
- quotient  output  WIDTH  signed quotient, destined for LO.
- remainder  output  WIDTH  signed remainder, destined for HI.
- div_by_zero  output  1  set with done when divisor was 0. Held with the results.

Behaviour:
- Reset (synchronous, any state): state <= IDLE. busy, done, div_by_zero, quotient and remainder all go to 0. An in-flight operation is abandoned and done never pulses for it.
- States: IDLE, ITER, FIX, DONE. All outputs are registered; busy and done are decoded from the registered state.
- IDLE:
  - With start=1, at edge E0: latch |dividend| into the Q shift register and |divisor| into M; clear the WIDTH+1-bit partial remainder A; latch sign_q = dividend[MSB]^divisor[MSB], sign_r = dividend[MSB] and dbz = (divisor==0); counter <= 0; state <= ITER.
  - Magnitude of 0x80000000 is 0x80000000, treated as unsigned.
- ITER (one iteration per edge, edges E1..E32):
  - Shift {A,Q} left by 1.
  - If A was non-negative, A <= A - M; otherwise A <= A + M.
  - Q[0] <= ~A_new[MSB].
  - Counter increments; at counter==WIDTH-1, state <= FIX.
- FIX (edge E33):
  - If A is negative, A <= A + M (remainder restore).
  - Apply signs: quotient = sign_q ? -Q : Q; remainder = sign_r ? -A[WIDTH-1:0] : A[WIDTH-1:0].
  - Register both outputs and div_by_zero <= dbz; state <= DONE.
- DONE: done=1 for exactly one cycle (the cycle after E33), busy=0; state <= IDLE on the next edge.
- Latency: done is high in the cycle following the 33rd rising edge after the edge that sampled start. busy is high for exactly 33 cycles.
- Semantics: truncating division toward zero. The remainder takes the dividend's sign, with |remainder| < |divisor|, so dividend == quotient*divisor + remainder (mod 2^32).
- Divide by zero: runs the full latency. Final outputs are quotient=0xFFFFFFFF, remainder=dividend (original signed value), div_by_zero=1, forced in FIX.
- Overflow: 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000, remainder=0, div_by_zero=0 (wraps; no flag).
- start while busy or in DONE: ignored. Operands are not re-sampled and the current operation is unaffected.
- start held high continuously: a new operation begins on the IDLE cycle after DONE, giving back-to-back ops every 35 cycles.
- Results (quotient, remainder, div_by_zero) hold their values from DONE until the FIX of the next operation. They are not cleared on start.
- Arithmetic: A is WIDTH+1 bits, so the sign bit is the A[WIDTH] MSB. Use a single shared adder/subtractor (M or ~M+1 selected) to perform each step.

Test Plan:
- dividend=100, divisor=7, pulse start -> 33 busy cycles then a done pulse; quotient=14 (0x0000000E), remainder=2, div_by_zero=0.
- dividend=-100 (0xFFFFFF9C), divisor=7 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2). Also 100/-7 -> quotient=-14, remainder=+2.
- dividend=7, divisor=0 -> done after full latency; quotient=0xFFFFFFFF, remainder=7, div_by_zero=1. The next op 9/3 gives quotient=3, remainder=0, div_by_zero=0.
- Edge values:
  - 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
  - 0x7FFFFFFF / 1 -> quotient=0x7FFFFFFF, remainder=0.
  - 5 / 9 -> quotient=0, remainder=5.
- Start 1000/10, then re-pulse start with 1/1 at cycle 5 -> ignored; the single done gives quotient=100, remainder=0. Assert reset at cycle 10 of a second op -> busy=0, outputs=0 next cycle, and no done pulse.
- Random signed pairs (non-zero divisor), 1000 iterations, compared against the bench's `/` and `%` operators. Check latency is exactly 33 busy cycles each time.
